// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_entry_t : one prefetched word tagged with its byte PC
//   fetch_state_t : fetch sequencer state (RUN fetching, END past the populated memory)
package instr_fetch_pkg;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN = 1'b0,
        END = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding fetch_entry_t words between the fetch PC and decode.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   push_i, wr_data_i    write an entry at the tail
//   pop_i                remove the head entry
//   flush_i              empty the queue; wins over push and pop
//   head_o               entry at the head (stale when empty)
//   empty_o, count_o     occupancy status
module fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           wr_data_i,
    output fetch_entry_t           head_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t           mem_r [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W:0]         count_r;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    // A push into a full queue together with a pop overwrites the slot being popped,
    // which is safe because the head is read before the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_i) begin
                mem_r[wr_ptr_r] <= wr_data_i;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_o  = mem_r[rd_ptr_r];
    assign empty_o = (count_r == '0);
    assign count_o = count_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: owns the fetch PC, reads the combinational instruction memory,
// prefetches sequential words into fetch_queue and hands {pc, instr} to decode.
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   imem_addr_o / imem_instr_i       instruction memory byte address / returned word
//   redirect_i, redirect_pc_i        taken branch/jump: flush and restart at the target
//   ready_i                          decode accepts the head entry
//   valid_o, instr_o, pc_o, pc_plus4_o   head entry presented to decode
//   halted_o                         fetch has run past the populated memory
//   fetch_cnt_o                      saturating count of delivered instructions
module instr_fetch_unit
    import instr_fetch_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          MEM_WORDS = 32,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [31:0]       imem_addr_o,
    input  logic [31:0]       imem_instr_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc_plus4_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  fetch_cnt_o
);

    localparam logic [31:0]          LIMIT     = 32'(MEM_WORDS * WORD_BYTES);
    localparam logic [31:0]          STEP      = 32'(WORD_BYTES);
    localparam logic [CNT_W-1:0]     CNT_MAX   = '1;
    localparam logic [$clog2(DEPTH):0] DEPTH_CNT = ($clog2(DEPTH) + 1)'(DEPTH);

    fetch_state_t              state_r;
    logic [31:0]               fetch_pc_r;
    logic [CNT_W-1:0]          fetch_cnt_r;

    fetch_entry_t              head_s;
    fetch_entry_t              wr_entry_s;
    logic                      q_empty_s;
    logic [$clog2(DEPTH):0]    q_count_s;
    logic                      pop_s;
    logic                      push_s;
    logic [31:0]               next_pc_s;
    logic [31:0]               target_pc_s;

    // A redirect hides the head in its own cycle, so nothing is popped then.
    assign valid_o     = ~q_empty_s & ~redirect_i;
    assign pop_s       = valid_o & ready_i;
    assign push_s      = (state_r == RUN) & ~redirect_i & ((q_count_s < DEPTH_CNT) | pop_s);
    assign next_pc_s   = fetch_pc_r + STEP;
    assign target_pc_s = {redirect_pc_i[31:2], 2'b00};
    assign wr_entry_s  = '{pc: fetch_pc_r, instr: imem_instr_i};

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push_s),
        .pop_i     (pop_s),
        .flush_i   (redirect_i),
        .wr_data_i (wr_entry_s),
        .head_o    (head_s),
        .empty_o   (q_empty_s),
        .count_o   (q_count_s)
    );

    // Fetch FSM and fetch PC: redirect wins; otherwise each push advances one word
    // and stepping onto or past LIMIT stops further pushes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= RUN;
            fetch_pc_r <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc_r <= target_pc_s;
            state_r    <= (target_pc_s >= LIMIT) ? END : RUN;
        end else if (push_s) begin
            fetch_pc_r <= next_pc_s;
            state_r    <= (next_pc_s >= LIMIT) ? END : RUN;
        end else begin
            fetch_pc_r <= fetch_pc_r;
            state_r    <= state_r;
        end
    end

    // Delivered-instruction counter, saturating at all ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_r <= '0;
        end else if (pop_s && (fetch_cnt_r != CNT_MAX)) begin
            fetch_cnt_r <= fetch_cnt_r + 1'b1;
        end else begin
            fetch_cnt_r <= fetch_cnt_r;
        end
    end

    assign imem_addr_o = fetch_pc_r;
    assign instr_o     = head_s.instr;
    assign pc_o        = head_s.pc;
    assign pc_plus4_o  = head_s.pc + STEP;
    assign halted_o    = (state_r == END);
    assign fetch_cnt_o = fetch_cnt_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by random
// ready/redirect traffic, all compared against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam int          DEPTH     = 4;
    localparam int          MEM_WORDS = 32;
    localparam logic [31:0] LIMIT     = 32'd128;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        rst_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        halted_o;
    logic [15:0] fetch_cnt_o;

    logic [31:0] mem [MEM_WORDS];

    // reference model state
    ent_t        mq[$];
    logic [31:0] m_fpc;
    logic        m_halted;
    logic [15:0] m_cnt;
    logic [31:0] dut_last_pc;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(
        .DEPTH     (DEPTH),
        .MEM_WORDS (MEM_WORDS),
        .RESET_PC  (32'h0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ready_i       (ready_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .halted_o      (halted_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational instruction memory
    always_comb begin
        imem_instr_i = 32'hDEAD_BEEF;
        if (imem_addr_o < LIMIT) imem_instr_i = mem[imem_addr_o[6:2]];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc    = 32'h0;
        m_halted = 1'b0;
        m_cnt    = 16'h0;
    endtask

    // called at a negedge: pulse reset before the next posedge, leave inputs idle
    task automatic do_reset();
        redirect_i = 1'b0;
        ready_i    = 1'b0;
        rst_i      = 1'b1;
        #2;
        rst_i = 1'b0;
        model_reset();
    endtask

    // one cycle: drive inputs, compare outputs against the model, advance the model
    task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
        logic exp_valid;
        logic do_pop;
        logic do_push;
        ent_t e;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        ready_i       = rdy;
        #1;
        exp_valid = (mq.size() != 0) && !rd;
        check_eq("valid_o", {31'b0, valid_o}, {31'b0, exp_valid});
        if (exp_valid) begin
            check_eq("pc_o", pc_o, mq[0].pc);
            check_eq("instr_o", instr_o, mq[0].instr);
            check_eq("pc_plus4_o", pc_plus4_o, mq[0].pc + 32'd4);
        end
        check_eq("halted_o", {31'b0, halted_o}, {31'b0, m_halted});
        check_eq("fetch_cnt_o", {16'b0, fetch_cnt_o}, {16'b0, m_cnt});
        check_eq("imem_addr_o", imem_addr_o, m_fpc);
        if (valid_o && rdy) dut_last_pc = pc_o;

        do_pop  = exp_valid && rdy;
        do_push = !m_halted && !rd && ((mq.size() < DEPTH) || do_pop);
        if (rd) begin
            mq.delete();
            m_fpc    = {rpc[31:2], 2'b00};
            m_halted = (m_fpc >= LIMIT);
        end else begin
            if (do_pop) begin
                void'(mq.pop_front());
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            if (do_push) begin
                e.pc    = m_fpc;
                e.instr = mem[m_fpc[6:2]];
                mq.push_back(e);
                m_fpc = m_fpc + 32'd4;
                if (m_fpc >= LIMIT) m_halted = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;

        for (int k = 0; k < MEM_WORDS; k++) mem[k] = 32'(k + 1);
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        ready_i       = 1'b0;
        dut_last_pc   = 32'hFFFF_FFFF;
        model_reset();

        // reset values
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_valid", {31'b0, valid_o}, 32'd0);
        check_eq("rst_instr", instr_o, 32'd0);
        check_eq("rst_pc", pc_o, 32'd0);
        check_eq("rst_pc4", pc_plus4_o, 32'd4);
        check_eq("rst_halted", {31'b0, halted_o}, 32'd0);
        check_eq("rst_cnt", {16'b0, fetch_cnt_o}, 32'd0);
        check_eq("rst_addr", imem_addr_o, 32'd0);
        do_reset();

        // streaming from reset with ready high
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

        // stall fills the queue, then drains with no bubble
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
        check_eq("stall_addr", imem_addr_o, 32'd16);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
        check_eq("drain_cnt", {16'b0, fetch_cnt_o}, 32'd6);

        // redirect while head pc is 8
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
        check_eq("pre_redir_pc", pc_o, 32'd8);
        step(1'b1, 32'h43, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check_eq("redir_valid", {31'b0, valid_o}, 32'd1);
        check_eq("redir_pc", pc_o, 32'h40);
        check_eq("redir_cnt", {16'b0, fetch_cnt_o}, 32'd2);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

        // run to the end of memory, then restart with a redirect to 0
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b0, 32'h0, 1'b1);
        check_eq("end_last_pc", dut_last_pc, 32'd124);
        check_eq("end_halted", {31'b0, halted_o}, 32'd1);
        check_eq("end_valid", {31'b0, valid_o}, 32'd0);
        check_eq("end_cnt", {16'b0, fetch_cnt_o}, 32'd32);
        step(1'b1, 32'h0, 1'b1);
        check_eq("restart_halted", {31'b0, halted_o}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

        // asynchronous reset with a full queue
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("arst_valid", {31'b0, valid_o}, 32'd0);
        check_eq("arst_cnt", {16'b0, fetch_cnt_o}, 32'd0);
        check_eq("arst_addr", imem_addr_o, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

        // counter saturation
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
        force dut.fetch_cnt_r = 16'hFFFE;
        #1;
        release dut.fetch_cnt_r;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
        check_eq("sat_cnt", {16'b0, fetch_cnt_o}, 32'h0000_FFFF);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

        // random traffic with random memory contents
        for (int k = 0; k < MEM_WORDS; k++) mem[k] = $urandom;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rd  = ($urandom_range(0, 15) == 0);
            rpc = 32'($urandom_range(0, 140));
            rdy = ($urandom_range(0, 3) != 0);
            step(rd, rpc, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
